// File: rtl/pcs_rx_link_ctrl_if.sv
// Signal bundle between the PCS receiver and the receive link bring-up sequencer.
// The flap-counter pair exists only when PCS_LINK_FLAP_CNT_EN is defined.
interface pcs_rx_link_ctrl_if;
    logic [3:0]  block_lock;
    logic [3:0]  am_lock;
    logic        align_status;
    logic        hi_ber;
    logic        rx_test_mode;
    logic        descrambler_reset;
    logic        deskew_restart;
    logic        PCS_status;
    logic [2:0]  link_state;
    logic        timeout_pulse;
    logic        link_down_pulse;
    logic [7:0]  restart_count;
`ifdef PCS_LINK_FLAP_CNT_EN
    logic        flap_clr;
    logic [15:0] flap_count;
`endif

    modport master (
        output block_lock,
        output am_lock,
        output align_status,
        output hi_ber,
        output rx_test_mode,
`ifdef PCS_LINK_FLAP_CNT_EN
        output flap_clr,
        input  flap_count,
`endif
        input  descrambler_reset,
        input  deskew_restart,
        input  PCS_status,
        input  link_state,
        input  timeout_pulse,
        input  link_down_pulse,
        input  restart_count
    );

    modport slave (
        input  block_lock,
        input  am_lock,
        input  align_status,
        input  hi_ber,
        input  rx_test_mode,
`ifdef PCS_LINK_FLAP_CNT_EN
        input  flap_clr,
        output flap_count,
`endif
        output descrambler_reset,
        output deskew_restart,
        output PCS_status,
        output link_state,
        output timeout_pulse,
        output link_down_pulse,
        output restart_count
    );
endinterface

// File: rtl/pcs_rx_link_ctrl.sv
// Receive link bring-up sequencer for the 4-lane PCS: INIT->BLOCK->AM->ALIGN->HOLD->UP with restart on
// bring-up timeout or link loss. Define PCS_LINK_FLAP_CNT_EN to add the flap_count/flap_clr pair.
module pcs_rx_link_ctrl #(
    parameter logic [15:0] LOCK_TIMEOUT = 16'd50000,
    parameter logic [15:0] UP_HOLD      = 16'd1024,
    parameter logic [3:0]  RST_PULSE    = 4'd4
) (
    input  logic              RX_CLK,
    input  logic              reset,
    pcs_rx_link_ctrl_if.slave link
);
    localparam logic [2:0] ST_INIT  = 3'd0;
    localparam logic [2:0] ST_BLOCK = 3'd1;
    localparam logic [2:0] ST_AM    = 3'd2;
    localparam logic [2:0] ST_ALIGN = 3'd3;
    localparam logic [2:0] ST_HOLD  = 3'd4;
    localparam logic [2:0] ST_UP    = 3'd5;

    localparam logic [15:0] TIMER_LAST = LOCK_TIMEOUT - 16'd1;
    localparam logic [15:0] HOLD_LAST  = UP_HOLD - 16'd1;
    localparam logic [3:0]  PULSE_LAST = RST_PULSE - 4'd1;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        if (v == 8'hFF) begin
            return v;
        end else begin
            return v + 8'd1;
        end
    endfunction

    logic [2:0]  state_q, state_d;
    logic [3:0]  pulse_cnt_q, pulse_cnt_d;
    logic [15:0] timer_q, timer_d;
    logic [15:0] hold_cnt_q, hold_cnt_d;
    logic [7:0]  restart_cnt_q, restart_cnt_d;
    logic        mode_q;
    logic        descr_rst_q;
    logic        deskew_rst_q;
    logic        pcs_status_q;
    logic        timeout_pulse_q;
    logic        link_down_pulse_q;

    logic block_ok_s;
    logic am_ok_s;
    logic align_ok_s;
    logic active_s;
    logic mode_chg_s;
    logic up_loss_s;
    logic timeout_s;
    logic link_drop_s;

    assign block_ok_s = (link.block_lock == 4'hF);
    assign am_ok_s    = (link.am_lock == 4'hF);
    assign align_ok_s = link.align_status;
    assign active_s   = (state_q == ST_BLOCK) || (state_q == ST_AM) ||
                        (state_q == ST_ALIGN) || (state_q == ST_HOLD);
    // A test-mode flip is only meaningful once the sequencer has left INIT.
    assign mode_chg_s = (state_q != ST_INIT) && (link.rx_test_mode != mode_q);
    assign up_loss_s  = !block_ok_s || (!link.rx_test_mode && !(am_ok_s && align_ok_s));

    // Next-state, pulse/timer/hold counters; timeout outranks every other transition.
    always_comb begin
        state_d     = state_q;
        pulse_cnt_d = pulse_cnt_q;
        timer_d     = timer_q;
        hold_cnt_d  = hold_cnt_q;
        timeout_s   = 1'b0;
        link_drop_s = 1'b0;
        if (state_q == ST_INIT) begin
            if (pulse_cnt_q == PULSE_LAST) begin
                state_d     = ST_BLOCK;
                pulse_cnt_d = 4'd0;
                timer_d     = 16'd0;
            end else begin
                pulse_cnt_d = pulse_cnt_q + 4'd1;
            end
        end else if (active_s && (timer_q == TIMER_LAST)) begin
            state_d     = ST_INIT;
            pulse_cnt_d = 4'd0;
            timeout_s   = 1'b1;
        end else if (mode_chg_s) begin
            state_d     = ST_INIT;
            pulse_cnt_d = 4'd0;
        end else begin
            if (active_s) begin
                timer_d = timer_q + 16'd1;
            end else begin
                timer_d = timer_q;
            end
            case (state_q)
                ST_BLOCK: begin
                    if (block_ok_s && link.rx_test_mode) begin
                        state_d    = ST_HOLD;
                        hold_cnt_d = 16'd0;
                    end else if (block_ok_s) begin
                        state_d = ST_AM;
                    end else begin
                        state_d = ST_BLOCK;
                    end
                end
                ST_AM: begin
                    if (!block_ok_s) begin
                        state_d = ST_BLOCK;
                    end else if (am_ok_s) begin
                        state_d = ST_ALIGN;
                    end else begin
                        state_d = ST_AM;
                    end
                end
                ST_ALIGN: begin
                    if (!block_ok_s) begin
                        state_d = ST_BLOCK;
                    end else if (!am_ok_s) begin
                        state_d = ST_AM;
                    end else if (align_ok_s) begin
                        state_d    = ST_HOLD;
                        hold_cnt_d = 16'd0;
                    end else begin
                        state_d = ST_ALIGN;
                    end
                end
                ST_HOLD: begin
                    if (!block_ok_s) begin
                        state_d = ST_BLOCK;
                    end else if (!link.rx_test_mode && !(am_ok_s && align_ok_s)) begin
                        state_d = ST_AM;
                    end else if (link.hi_ber) begin
                        hold_cnt_d = 16'd0;
                    end else if (hold_cnt_q == HOLD_LAST) begin
                        state_d = ST_UP;
                    end else begin
                        hold_cnt_d = hold_cnt_q + 16'd1;
                    end
                end
                ST_UP: begin
                    if (up_loss_s) begin
                        state_d     = ST_INIT;
                        pulse_cnt_d = 4'd0;
                        link_drop_s = 1'b1;
                    end else begin
                        state_d = ST_UP;
                    end
                end
                default: begin
                    state_d     = ST_INIT;
                    pulse_cnt_d = 4'd0;
                end
            endcase
        end
    end

    // Restart statistics: timeouts and link drops share one saturating counter.
    always_comb begin
        if (timeout_s || link_drop_s) begin
            restart_cnt_d = sat_inc8(restart_cnt_q);
        end else begin
            restart_cnt_d = restart_cnt_q;
        end
    end

    // Sequencer state and counters.
    always_ff @(posedge RX_CLK or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_INIT;
            pulse_cnt_q   <= 4'd0;
            timer_q       <= 16'd0;
            hold_cnt_q    <= 16'd0;
            restart_cnt_q <= 8'd0;
            mode_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            pulse_cnt_q   <= pulse_cnt_d;
            timer_q       <= timer_d;
            hold_cnt_q    <= hold_cnt_d;
            restart_cnt_q <= restart_cnt_d;
            mode_q        <= link.rx_test_mode;
        end
    end

    // Registered outputs follow the next state so they change on the same edge as link_state.
    always_ff @(posedge RX_CLK or negedge reset) begin
        if (!reset) begin
            descr_rst_q       <= 1'b1;
            deskew_rst_q      <= 1'b1;
            pcs_status_q      <= 1'b0;
            timeout_pulse_q   <= 1'b0;
            link_down_pulse_q <= 1'b0;
        end else begin
            descr_rst_q       <= (state_d == ST_INIT);
            deskew_rst_q      <= (state_d == ST_INIT);
            pcs_status_q      <= (state_d == ST_UP) && !link.hi_ber;
            timeout_pulse_q   <= timeout_s;
            link_down_pulse_q <= link_drop_s;
        end
    end

    assign link.descrambler_reset = descr_rst_q;
    assign link.deskew_restart    = deskew_rst_q;
    assign link.PCS_status        = pcs_status_q;
    assign link.link_state        = state_q;
    assign link.timeout_pulse     = timeout_pulse_q;
    assign link.link_down_pulse   = link_down_pulse_q;
    assign link.restart_count     = restart_cnt_q;

`ifdef PCS_LINK_FLAP_CNT_EN
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        if (v == 16'hFFFF) begin
            return v;
        end else begin
            return v + 16'd1;
        end
    endfunction

    logic [15:0] flap_cnt_q, flap_cnt_d;

    // A clear coinciding with a drop still records that drop.
    always_comb begin
        if (link.flap_clr) begin
            flap_cnt_d = link_drop_s ? 16'd1 : 16'd0;
        end else if (link_drop_s) begin
            flap_cnt_d = sat_inc16(flap_cnt_q);
        end else begin
            flap_cnt_d = flap_cnt_q;
        end
    end

    // Link flap counter.
    always_ff @(posedge RX_CLK or negedge reset) begin
        if (!reset) begin
            flap_cnt_q <= 16'd0;
        end else begin
            flap_cnt_q <= flap_cnt_d;
        end
    end

    assign link.flap_count = flap_cnt_q;
`endif
endmodule

// File: tb/tb_pcs_rx_link_ctrl.sv
// Scoreboard bench for pcs_rx_link_ctrl: stimulus queues expected output-change events (with the number of
// active clock edges since the previous event); a monitor pops and compares on every observed change.
module tb_pcs_rx_link_ctrl;
    localparam logic [15:0] LT = 16'd80;
    localparam logic [15:0] UH = 16'd16;
    localparam logic [3:0]  RP = 4'd4;
`ifdef PCS_LINK_FLAP_CNT_EN
    localparam bit FLAP_EN = 1'b1;
`else
    localparam bit FLAP_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    pcs_rx_link_ctrl_if link();

    pcs_rx_link_ctrl #(.LOCK_TIMEOUT(LT), .UP_HOLD(UH), .RST_PULSE(RP)) dut (
        .RX_CLK (clk),
        .reset  (rst_n),
        .link   (link)
    );

    typedef struct packed {
        logic [2:0]  st;
        logic        dr;
        logic        ds;
        logic        pcs;
        logic        to;
        logic        ld;
        logic [7:0]  rc;
        logic [15:0] flap;
    } obs_t;

    typedef struct {
        obs_t o;
        int   delta;
        int   tag;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;
    int   tag_n = 0;
    int   edge_cnt = 0;

    // Active edges: those the DUT sees with reset released.
    always @(posedge clk) if (rst_n) edge_cnt <= edge_cnt + 1;

    task automatic push_exp(input int st, input int pcs, input int to, input int ld,
                            input int rc, input int fl, input int d);
        exp_t e;
        e.o.st   = st[2:0];
        e.o.dr   = (st == 0);
        e.o.ds   = (st == 0);
        e.o.pcs  = pcs[0];
        e.o.to   = to[0];
        e.o.ld   = ld[0];
        e.o.rc   = rc[7:0];
        e.o.flap = FLAP_EN ? fl[15:0] : 16'd0;
        e.delta  = d;
        e.tag    = tag_n;
        tag_n++;
        q.push_back(e);
    endtask

    function automatic obs_t sample();
        obs_t o;
        o.st  = link.link_state;
        o.dr  = link.descrambler_reset;
        o.ds  = link.deskew_restart;
        o.pcs = link.PCS_status;
        o.to  = link.timeout_pulse;
        o.ld  = link.link_down_pulse;
        o.rc  = link.restart_count;
`ifdef PCS_LINK_FLAP_CNT_EN
        o.flap = link.flap_count;
`else
        o.flap = 16'd0;
`endif
        return o;
    endfunction

    initial begin : monitor
        obs_t cur;
        obs_t prev;
        exp_t e;
        bit   first;
        int   last_edge;
        int   dt;
        first = 1'b1;
        last_edge = 0;
        prev = '0;
        forever begin
            @(negedge clk);
            cur = sample();
            if (first || (cur !== prev)) begin
                dt = edge_cnt - last_edge;
                total++;
                if (q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_event: got st=%0d pcs=%0b to=%0b ld=%0b rc=%0d flap=%0d dt=%0d, want no event",
                             cur.st, cur.pcs, cur.to, cur.ld, cur.rc, cur.flap, dt);
                end else begin
                    e = q.pop_front();
                    if ((cur !== e.o) || (dt != e.delta)) begin
                        bad++;
                        $display("FAIL event%0d: got st=%0d dr=%0b ds=%0b pcs=%0b to=%0b ld=%0b rc=%0d flap=%0d dt=%0d, want st=%0d dr=%0b ds=%0b pcs=%0b to=%0b ld=%0b rc=%0d flap=%0d dt=%0d",
                                 e.tag, cur.st, cur.dr, cur.ds, cur.pcs, cur.to, cur.ld, cur.rc, cur.flap, dt,
                                 e.o.st, e.o.dr, e.o.ds, e.o.pcs, e.o.to, e.o.ld, e.o.rc, e.o.flap, e.delta);
                    end
                end
                prev = cur;
                first = 1'b0;
                last_edge = edge_cnt;
            end
        end
    end

    initial begin : watchdog
        #(2000000);
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget);
        int k;
        k = 0;
        while ((link.link_state !== s) && (k < budget)) begin
            @(negedge clk);
            k++;
        end
        if (link.link_state !== s) begin
            total++;
            bad++;
            $display("FAIL wait_state: link_state=%0d after %0d cycles, want %0d", link.link_state, k, s);
        end
    endtask

    task automatic wait_to(input int budget);
        int k;
        k = 0;
        while ((link.timeout_pulse !== 1'b1) && (k < budget)) begin
            @(negedge clk);
            k++;
        end
        if (link.timeout_pulse !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL wait_timeout: timeout_pulse=%0b after %0d cycles, want 1", link.timeout_pulse, k);
        end
    endtask

    task automatic set_flap_clr(input logic v);
`ifdef PCS_LINK_FLAP_CNT_EN
        link.flap_clr = v;
`else
        if (v) begin
            tag_n = tag_n + 0;
        end
`endif
    endtask

    initial begin : stim
        int rcv;
        link.block_lock   = 4'hF;
        link.am_lock      = 4'hF;
        link.align_status = 1'b1;
        link.hi_ber       = 1'b0;
        link.rx_test_mode = 1'b0;
        set_flap_clr(1'b0);
        rst_n = 1'b1;

        // Bring-up from reset with every lock already present.
        push_exp(0, 0, 0, 0, 0, 0, 0);
        push_exp(1, 0, 0, 0, 0, 0, 4);
        push_exp(2, 0, 0, 0, 0, 0, 1);
        push_exp(3, 0, 0, 0, 0, 0, 1);
        push_exp(4, 0, 0, 0, 0, 0, 1);
        push_exp(5, 1, 0, 0, 0, 0, 16);
        #1 rst_n = 1'b0;
        tick(3);
        #2 rst_n = 1'b1;
        wait_state(3'd5, 60);

        // hi_ber in UP masks PCS_status without leaving UP.
        push_exp(5, 0, 0, 0, 0, 0, 1);
        link.hi_ber = 1'b1;
        tick(3);
        push_exp(5, 1, 0, 0, 0, 0, 3);
        link.hi_ber = 1'b0;
        tick(2);

        // One-cycle am_lock[2] drop in UP, then full re-bring-up.
        push_exp(0, 0, 0, 1, 1, 1, 2);
        push_exp(0, 0, 0, 0, 1, 1, 1);
        push_exp(1, 0, 0, 0, 1, 1, 3);
        push_exp(2, 0, 0, 0, 1, 1, 1);
        push_exp(3, 0, 0, 0, 1, 1, 1);
        push_exp(4, 0, 0, 0, 1, 1, 1);
        push_exp(5, 1, 0, 0, 1, 1, 16);
        link.am_lock = 4'hB;
        tick(1);
        link.am_lock = 4'hF;
        wait_state(3'd5, 60);

        // Lane 0 block lock lost: link drop, then a bring-up timeout after LT cycles in BLOCK.
        push_exp(0, 0, 0, 1, 2, 2, 1);
        push_exp(0, 0, 0, 0, 2, 2, 1);
        push_exp(1, 0, 0, 0, 2, 2, 3);
        push_exp(0, 0, 1, 0, 3, 2, 80);
        push_exp(0, 0, 0, 0, 3, 2, 1);
        push_exp(1, 0, 0, 0, 3, 2, 3);
        link.block_lock = 4'hE;
        wait_to(200);
        wait_state(3'd1, 10);

        // Test-mode flip in BLOCK restarts silently; test mode skips AM/ALIGN; hi_ber restarts the hold.
        push_exp(0, 0, 0, 0, 3, 2, 1);
        push_exp(1, 0, 0, 0, 3, 2, 4);
        push_exp(4, 0, 0, 0, 3, 2, 1);
        push_exp(5, 1, 0, 0, 3, 2, 22);
        link.rx_test_mode = 1'b1;
        link.am_lock      = 4'h0;
        link.align_status = 1'b0;
        link.block_lock   = 4'hF;
        wait_state(3'd4, 20);
        tick(5);
        link.hi_ber = 1'b1;
        tick(1);
        link.hi_ber = 1'b0;
        wait_state(3'd5, 40);

        // Drop with a same-cycle flap clear, then 300 forced timeouts saturating restart_count.
        push_exp(0, 0, 0, 1, 4, 1, 1);
        push_exp(0, 0, 0, 0, 4, 1, 1);
        push_exp(1, 0, 0, 0, 4, 1, 3);
        for (int i = 0; i < 300; i++) begin
            rcv = ((5 + i) > 255) ? 255 : (5 + i);
            push_exp(0, 0, 1, 0, rcv, 1, 80);
            push_exp(0, 0, 0, 0, rcv, 1, 1);
            push_exp(1, 0, 0, 0, rcv, 1, 3);
        end
        link.block_lock = 4'hE;
        set_flap_clr(1'b1);
        tick(1);
        set_flap_clr(1'b0);
        for (int i = 0; i < 300; i++) begin
            wait_to(200);
            wait_state(3'd1, 10);
        end

        // Short asynchronous reset pulse between clock edges aborts mid-bring-up.
        push_exp(0, 0, 0, 0, 0, 0, 11);
        push_exp(1, 0, 0, 0, 0, 0, 3);
        push_exp(4, 0, 0, 0, 0, 0, 1);
        push_exp(5, 1, 0, 0, 0, 0, 16);
        tick(10);
        #2;
        rst_n = 1'b0;
        link.block_lock = 4'hF;
        #2;
        rst_n = 1'b1;
        wait_state(3'd5, 40);
        tick(3);

        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL pending_events: %0d expected events not observed, want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
